// File: rtl/sobel_tap_select_if.sv
// Tap-select bundle: per-tap video inputs, tap request and the selected, registered video outputs.
interface sobel_tap_select_if #(
    parameter int COLORDEPTH = 8,
    parameter int NUM_TAPS   = 6
);
    logic [NUM_TAPS-2:0]                 sw;
    logic [NUM_TAPS-1:0][COLORDEPTH-1:0] tap_red_i;
    logic [NUM_TAPS-1:0][COLORDEPTH-1:0] tap_green_i;
    logic [NUM_TAPS-1:0][COLORDEPTH-1:0] tap_blue_i;
    logic [NUM_TAPS-1:0]                 tap_dv_i;
    logic [NUM_TAPS-1:0]                 tap_hs_i;
    logic [NUM_TAPS-1:0]                 tap_vs_i;
    logic [COLORDEPTH-1:0]               red_o;
    logic [COLORDEPTH-1:0]               green_o;
    logic [COLORDEPTH-1:0]               blue_o;
    logic                                dv_o;
    logic                                hs_o;
    logic                                vs_o;
    logic [3:0]                          sel_o;
    logic                                switch_o;

    modport master (
        output sw, tap_red_i, tap_green_i, tap_blue_i, tap_dv_i, tap_hs_i, tap_vs_i,
        input  red_o, green_o, blue_o, dv_o, hs_o, vs_o, sel_o, switch_o
    );

    modport slave (
        input  sw, tap_red_i, tap_green_i, tap_blue_i, tap_dv_i, tap_hs_i, tap_vs_i,
        output red_o, green_o, blue_o, dv_o, hs_o, vs_o, sel_o, switch_o
    );
endinterface

// File: rtl/sobel_tap_select.sv
// Selects one pipeline tap for display; the active tap only changes on its own vsync rising edge.
// Optional border overlay (all-ones frame around the active area) is enabled by SOBEL_TAP_BORDER_EN.
module sobel_tap_select #(
    parameter int COLORDEPTH = 8,
    parameter int NUM_TAPS   = 6,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720
) (
    input logic              clk,
    input logic              rst,
    sobel_tap_select_if.slave bus
);
    localparam int IW = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

    logic [3:0]            dec_idx;
    logic [NUM_TAPS-2:0]   hot;
    logic [3:0]            pend_q;
    logic [3:0]            sel_q;
    logic                  switch_q;
    logic [IW-1:0]         sel_idx;
    logic                  vs_prev_q;
    logic                  vs_cur;
    logic                  vs_rise;
    logic [COLORDEPTH-1:0] red_mux, green_mux, blue_mux;
    logic [COLORDEPTH-1:0] red_q, green_q, blue_q;
    logic                  dv_q, hs_q, vs_q;

    assign sel_idx = sel_q[IW-1:0];
    assign vs_cur  = bus.tap_vs_i[sel_idx];
    assign vs_rise = vs_cur & ~vs_prev_q;

    // Anything other than zero or exactly one bit set falls back to tap 0.
    always_comb begin
        dec_idx = '0;
        hot     = '0;
        for (int k = 0; k < NUM_TAPS - 1; k++) begin
            hot    = '0;
            hot[k] = 1'b1;
            if (bus.sw == hot) dec_idx = 4'(k + 1);
        end
    end

`ifdef SOBEL_TAP_BORDER_EN
    localparam int CW = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;
    localparam int LW = (V_ACTIVE > 2) ? $clog2(V_ACTIVE) : 1;

    logic [CW-1:0] col_q;
    logic [LW-1:0] line_q;
    logic          dv_prev_q;
    logic          dv_cur;
    logic          border_px;

    assign dv_cur    = bus.tap_dv_i[sel_idx];
    assign border_px = dv_cur && ((col_q == '0) || (col_q == CW'(H_ACTIVE - 1)) ||
                                  (line_q == '0) || (line_q == LW'(V_ACTIVE - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            line_q    <= '0;
            dv_prev_q <= 1'b0;
        end else begin
            dv_prev_q <= dv_cur;
            if (dv_cur) begin
                if (col_q != CW'(H_ACTIVE - 1)) col_q <= col_q + 1'b1;
            end else if (dv_prev_q) begin
                col_q <= '0;
            end
            // A new frame wins over an end-of-line in the same cycle.
            if (vs_rise) begin
                line_q <= '0;
            end else if (dv_prev_q && !dv_cur && (line_q != LW'(V_ACTIVE - 1))) begin
                line_q <= line_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        red_mux   = bus.tap_red_i[sel_idx];
        green_mux = bus.tap_green_i[sel_idx];
        blue_mux  = bus.tap_blue_i[sel_idx];
`ifdef SOBEL_TAP_BORDER_EN
        if (border_px) begin
            red_mux   = '1;
            green_mux = '1;
            blue_mux  = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            sel_q     <= '0;
            switch_q  <= 1'b0;
            vs_prev_q <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            dv_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            pend_q    <= dec_idx;
            vs_prev_q <= vs_cur;
            // Outputs use the tap selected before this cycle's possible switch.
            red_q     <= red_mux;
            green_q   <= green_mux;
            blue_q    <= blue_mux;
            dv_q      <= bus.tap_dv_i[sel_idx];
            hs_q      <= bus.tap_hs_i[sel_idx];
            vs_q      <= vs_cur;
            if (vs_rise) begin
                sel_q    <= pend_q;
                switch_q <= (pend_q != sel_q);
            end else begin
                switch_q <= 1'b0;
            end
        end
    end

    assign bus.red_o    = red_q;
    assign bus.green_o  = green_q;
    assign bus.blue_o   = blue_q;
    assign bus.dv_o     = dv_q;
    assign bus.hs_o     = hs_q;
    assign bus.vs_o     = vs_q;
    assign bus.sel_o    = sel_q;
    assign bus.switch_o = switch_q;
endmodule
